// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and default constants for the fetch PC generator.
package pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam int          DEF_STEP     = 4;

    typedef enum logic {S_RUN, S_PEND} state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_REDIR,
        SEL_PEND,
        SEL_EXC,
        SEL_ERET
    } sel_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one redirect target that arrived while fetch could not advance.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_pc
);

    state_t state, state_next;

    // capture while already pending simply overwrites the older target
    always_comb state_next = capture ? S_PEND : clear ? S_RUN : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RUN;
            pend_pc <= '0;
        end else begin
            state <= state_next;
            if (capture) pend_pc <= target;
        end
    end

    assign pend_valid = (state == S_PEND);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with exception/eret/redirect priority and
// a one-entry buffer for redirects that arrive during a stall.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(DEF_EXC_VEC),
    parameter int                STEP     = DEF_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              if_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              pend_valid,
    output logic              adel
);

    logic              adv;
    logic              capture;
    logic              clear;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] pc_next;
    sel_t              sel;

    assign adv = pc_valid & if_ready & ~stall;

    always_comb begin
        sel = exc_req                ? SEL_EXC   :
              eret_req               ? SEL_ERET  :
              redirect_valid & adv   ? SEL_REDIR :
              redirect_valid         ? SEL_HOLD  :
              pend_valid & adv       ? SEL_PEND  :
              adv                    ? SEL_SEQ   : SEL_HOLD;
        pc_next = sel == SEL_EXC   ? EXC_VEC              :
                  sel == SEL_ERET  ? epc                  :
                  sel == SEL_REDIR ? redirect_pc          :
                  sel == SEL_PEND  ? pend_pc              :
                  sel == SEL_SEQ   ? pc + ADDR_W'(STEP)   : pc;
    end

    // capture and clear are mutually exclusive: capture requires ~adv
    assign capture = ~exc_req & ~eret_req & redirect_valid & ~adv;
    assign clear   = exc_req | eret_req | adv;

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .clear      (clear),
        .target     (redirect_pc),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
        end else begin
            pc       <= pc_next;
            pc_valid <= 1'b1;
            flush    <= exc_req | eret_req;
        end
    end

    assign adel = |pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; each step queues its expected
// outputs when driven and pops them one cycle later when the DUT has updated.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        pend_valid;
    logic        adel;

    typedef struct {
        sel_t        sel;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        pend;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .pend_valid     (pend_valid),
        .adel           (adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input logic rst, input logic stl, input logic rdy,
                        input logic rv, input logic [31:0] rpc,
                        input logic ex, input logic er, input logic [31:0] e,
                        input sel_t sel, input logic [31:0] want_pc,
                        input logic want_valid, input logic want_flush, input logic want_pend);
        exp_t x;
        exp_t got;
        reset = rst; stall = stl; if_ready = rdy;
        redirect_valid = rv; redirect_pc = rpc;
        exc_req = ex; eret_req = er; epc = e;
        x.sel = sel; x.pc = want_pc; x.valid = want_valid;
        x.flush = want_flush; x.pend = want_pend; x.adel = |want_pc[1:0];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0)
        else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk({got.sel.name(), " pc"}, pc, got.pc);
            chk({got.sel.name(), " pc_valid"}, {31'b0, pc_valid}, {31'b0, got.valid});
            chk({got.sel.name(), " flush"}, {31'b0, flush}, {31'b0, got.flush});
            chk({got.sel.name(), " pend_valid"}, {31'b0, pend_valid}, {31'b0, got.pend});
            chk({got.sel.name(), " adel"}, {31'b0, adel}, {31'b0, got.adel});
        end
    endtask

    initial begin
        // reset and free-run
        step(1, 0, 1, 0, 0, 0, 0, 0, SEL_HOLD, 32'h3000, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, SEL_HOLD, 32'h3000, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_HOLD, 32'h3000, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h3004, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h3008, 1, 0, 0);
        // redirect during a two-cycle stall is buffered, taken on release
        step(0, 1, 1, 1, 32'h3100, 0, 0, 0, SEL_HOLD, 32'h3008, 1, 0, 1);
        step(0, 1, 1, 1, 32'h3100, 0, 0, 0, SEL_HOLD, 32'h3008, 1, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_PEND, 32'h3100, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h3104, 1, 0, 0);
        // newer redirect overwrites the buffered one
        step(0, 1, 1, 1, 32'h3100, 0, 0, 0, SEL_HOLD, 32'h3104, 1, 0, 1);
        step(0, 1, 1, 1, 32'h3200, 0, 0, 0, SEL_HOLD, 32'h3104, 1, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_PEND, 32'h3200, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h3204, 1, 0, 0);
        // unstalled redirect, then exception beats pending and new redirect under stall
        step(0, 0, 1, 1, 32'h3040, 0, 0, 0, SEL_REDIR, 32'h3040, 1, 0, 0);
        step(0, 1, 1, 1, 32'h3600, 0, 0, 0, SEL_HOLD,  32'h3040, 1, 0, 1);
        step(0, 1, 1, 1, 32'h3500, 1, 0, 0, SEL_EXC,   32'h4180, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ, 32'h4184, 1, 0, 0);
        // eret, then exc+eret together, then back-to-back exception
        step(0, 0, 1, 0, 0, 0, 1, 32'h3044, SEL_ERET, 32'h3044, 1, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1, 32'h3044, SEL_EXC,  32'h4180, 1, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0, SEL_EXC,  32'h4180, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h4184, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, SEL_HOLD, 32'h4184, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 32'h3010, SEL_ERET, 32'h3010, 1, 1, 0);
        // wrap-around, misaligned target, reset in the pending state
        step(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, SEL_REDIR, 32'hFFFF_FFFC, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ, 32'h0000_0000, 1, 0, 0);
        step(0, 0, 1, 1, 32'h3002, 0, 0, 0, SEL_REDIR, 32'h3002, 1, 0, 0);
        step(0, 1, 1, 1, 32'h3400, 0, 0, 0, SEL_HOLD,  32'h3002, 1, 0, 1);
        step(1, 0, 1, 1, 32'h3400, 1, 0, 0, SEL_HOLD,  32'h3000, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_HOLD, 32'h3000, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, SEL_SEQ,  32'h3004, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage of the pipelined MIPS core.
- Holds the fetch PC and advances it by STEP when the fetch can advance.
- Applies exception entry, eret return and branch/jump redirects in a fixed priority.
- Buffers a redirect that arrives while fetch is stalled, so it is never lost.
- Emits a one-cycle flush pulse to the decode stage on exception entry and eret.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_PC, 32'h0000_3000, PC value loaded by reset
EXC_VEC, 32'h0000_4180, exception entry address
STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
stall  in  1  hazard stall from decode; blocks sequential advance and redirects
if_ready  in  1  instruction memory accepts the current PC this cycle
redirect_valid  in  1  branch/jump resolved in decode, target on redirect_pc
redirect_pc  in  ADDR_W  branch/jump target
exc_req  in  1  exception/interrupt taken by CP0 this cycle
eret_req  in  1  eret committing this cycle
epc  in  ADDR_W  return address from CP0, valid with eret_req
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a real fetch request; 0 only in the cycle after reset
flush  out  1  registered one-cycle pulse: kill the instruction in decode
pend_valid  out  1  a buffered redirect is waiting
adel  out  1  combinational: pc[1:0] != 0, fetch address error to CP0

Behaviour:
- Reset (clk edge with reset=1):
  - pc=RESET_PC, pc_valid=0, flush=0, pend_valid=0, pend_pc=0, state=S_RUN.
  - Reset overrides every other input, including in mid-pending state.
- Cycle after reset deasserts: pc_valid=1. pc_valid then stays 1 until the next reset.
- Define adv = pc_valid & if_ready & ~stall.
- Per-edge priority (first match wins):
  1. exc_req: pc<=EXC_VEC regardless of stall or if_ready; pend cleared; flush<=1.
  2. eret_req: pc<=epc; pend cleared; flush<=1.
  3. redirect_valid & adv: pc<=redirect_pc; pend cleared. A new redirect beats any pending one.
  4. redirect_valid & ~adv: pend_pc<=redirect_pc, pend_valid<=1, pc unchanged. A newer redirect overwrites an existing pend_pc.
  5. pend_valid & adv: pc<=pend_pc, pend_valid<=0.
  6. adv: pc<=pc+STEP, truncated to ADDR_W bits, so wrap-around at 2^ADDR_W is modulo.
  7. Otherwise: pc holds.
- flush is 0 on every edge not covered by priority 1 or 2. Back-to-back exc_req gives back-to-back flush pulses.
- exc_req and eret_req together: exception wins, and eret is ignored.
- States: S_RUN (pend_valid=0) and S_PEND (pend_valid=1).
  - RUN->PEND on case 4.
  - PEND->RUN on cases 1, 2, 3 and 5.
  - pend_valid is the state bit.
- Latency: redirect/exc/eret affect pc one cycle after assertion. No combinational path from any input to pc.
- adel is combinational from pc only. A misaligned redirect target is loaded as-is; the exception decision belongs to CP0.

Decomposition:
- Package pc_gen_pkg:
  - state typedef {S_RUN, S_PEND}.
  - default RESET_PC, EXC_VEC and STEP constants.
  - a next-pc select enum {SEL_HOLD, SEL_SEQ, SEL_REDIR, SEL_PEND, SEL_EXC, SEL_ERET} used by both the RTL and the bench.
- One natural sub-module: pc_redirect_buf, holding pend_pc/pend_valid with capture, overwrite and clear inputs. The priority mux stays in the top.

Test Plan:
1. Reset then free-run with if_ready=1, stall=0 -> pc_valid 0 then 1; pc 0x3000, 0x3004, 0x3008 on consecutive cycles; flush=0.
2. At pc=0x3008 assert redirect_valid, redirect_pc=0x3100 with stall=1 for 2 cycles -> pc holds 0x3008, pend_valid=1. Release stall -> next pc=0x3100, pend_valid=0.
3. In S_PEND (pend_pc=0x3100) assert new redirect 0x3200 while stalled, then release -> pc=0x3200; 0x3100 is never fetched.
4. exc_req together with redirect_valid and stall=1 at pc=0x3040 -> next pc=0x4180, flush=1 for exactly one cycle, pend_valid=0.
5. eret_req with epc=0x3044 and exc_req=0 -> pc=0x3044, flush pulse. Then exc_req and eret_req together -> pc=0x4180.
6. ADDR_W=32, redirect to 0xFFFF_FFFC, free-run -> pc wraps to 0x0000_0000 with adel=0. Redirect to 0x3002 -> adel=1 the following cycle. Reset asserted while in S_PEND -> pc=0x3000, pend_valid=0.
